// File: rtl/btn_mode_ctrl_pkg.sv
// btn_pkg: shared FSM state type and default constants for the button mode controller
package btn_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT2 = 1'b1} state_e;
  localparam int DBL_WIN_50M   = 12_500_000;
  localparam int NUM_MODES_DEF = 4;
endpackage

// File: rtl/btn_mode_ctrl_if.sv
// btn_mode_ctrl_if: tick in, mode/mode_chg/single_evt/double_evt/busy out; master = controller, slave = consumer
interface btn_mode_ctrl_if #(parameter int MODE_W = 2);
  logic              tick;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;
  logic              single_evt;
  logic              double_evt;
  logic              busy;
  modport master (input tick, output mode, mode_chg, single_evt, double_evt, busy);
  modport slave (output tick, input mode, mode_chg, single_evt, double_evt, busy);
endinterface

// File: rtl/btn_mode_ctrl_tick_rise_det.sv
// tick_rise_det: clk, rst_n (async low), tick in, rise out; tick_q resets high so a tick held across reset is ignored
module tick_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic rise
);
  logic tick_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tick_q <= 1'b1;
    else tick_q <= tick;
  assign rise = tick & ~tick_q;
endmodule

// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: clk, rst_n (async low), bus (master: tick in; mode, mode_chg, single_evt, double_evt, busy out); classifies single/double presses
module btn_mode_ctrl
  import btn_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEF,
  parameter int MODE_W    = 2,
  parameter int DBL_WIN   = DBL_WIN_50M,
  parameter int CNT_W     = 24,
  parameter int WRAP      = 1
) (
  input logic             clk,
  input logic             rst_n,
  btn_mode_ctrl_if.master bus
);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(DBL_WIN - 1);
  logic              rise;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d, mode_nxt;
  logic              mode_chg_q, mode_chg_d;
  logic              single_q, single_d;
  logic              double_q, double_d;
  logic              busy_q, busy_d;
  tick_rise_det u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (bus.tick),
    .rise (rise)
  );
  assign mode_nxt = mode_q != MODE_MAX ? mode_q + 1'b1 : (WRAP != 0 ? '0 : MODE_MAX);
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    mode_d    = mode_q;
    single_d  = 1'b0;
    double_d  = 1'b0;
    if (state_q == IDLE) begin
      if (rise) begin
        state_d   = WAIT2;
        win_cnt_d = '0;
      end
    end else begin
      win_cnt_d = win_cnt_q + 1'b1;
      // a rise on the expiry edge itself still counts as the second press
      if (rise) begin
        double_d = 1'b1;
        mode_d   = '0;
        state_d  = IDLE;
      end else if (win_cnt_q == WIN_LAST) begin
        single_d = 1'b1;
        mode_d   = mode_nxt;
        state_d  = IDLE;
      end
    end
    mode_chg_d = single_d | double_d;
    busy_d     = state_d == WAIT2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      mode_q     <= '0;
      mode_chg_q <= 1'b0;
      single_q   <= 1'b0;
      double_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      single_q   <= single_d;
      double_q   <= double_d;
      busy_q     <= busy_d;
    end
  assign bus.mode       = mode_q;
  assign bus.mode_chg   = mode_chg_q;
  assign bus.single_evt = single_q;
  assign bus.double_evt = double_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_btn_mode_ctrl.sv
// tb_btn_mode_ctrl: randomized and directed checks of btn_mode_ctrl (WRAP=1 and WRAP=0) against an edge-index reference model
module tb_btn_mode_ctrl;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  btn_mode_ctrl_if #(.MODE_W(2)) if1 ();
  btn_mode_ctrl_if #(.MODE_W(2)) if0 ();
  assign if1.tick = tick;
  assign if0.tick = tick;
  btn_mode_ctrl #(.NUM_MODES(N), .MODE_W(2), .DBL_WIN(W), .CNT_W(4), .WRAP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  btn_mode_ctrl #(.NUM_MODES(N), .MODE_W(2), .DBL_WIN(W), .CNT_W(4), .WRAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  int edge_n = 0;
  int m_t0 = 0;
  int m_mode1 = 0;
  int m_mode0 = 0;
  bit m_pend, m_prev, m_s, m_d;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pend  <= 1'b0;
      m_prev  <= 1'b1;
      m_s     <= 1'b0;
      m_d     <= 1'b0;
      m_mode1 <= 0;
      m_mode0 <= 0;
    end else begin
      m_prev <= tick;
      edge_n <= edge_n + 1;
      m_s    <= 1'b0;
      m_d    <= 1'b0;
      if (m_pend && tick && !m_prev && edge_n - m_t0 <= W) begin
        m_d     <= 1'b1;
        m_pend  <= 1'b0;
        m_mode1 <= 0;
        m_mode0 <= 0;
      end else if (m_pend && edge_n - m_t0 == W) begin
        m_s     <= 1'b1;
        m_pend  <= 1'b0;
        m_mode1 <= (m_mode1 + 1) % N;
        m_mode0 <= (m_mode0 < N - 1) ? m_mode0 + 1 : N - 1;
      end else if (!m_pend && tick && !m_prev) begin
        m_pend <= 1'b1;
        m_t0   <= edge_n;
      end
    end
  wire [11:0] got = {if1.mode, if1.mode_chg, if1.single_evt, if1.double_evt, if1.busy,
                     if0.mode, if0.mode_chg, if0.single_evt, if0.double_evt, if0.busy};
  wire [11:0] exp = {m_mode1[1:0], m_s | m_d, m_s, m_d, m_pend,
                     m_mode0[1:0], m_s | m_d, m_s, m_d, m_pend};
  task automatic cyc(input logic t);
    @(negedge clk);
    tick = t;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1);
      checks++;
      if (got !== 12'h000) begin errors++; $display("FAIL reset_hold cyc %0d got=%h exp=000", i, got); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_model cyc %0d got=%h exp=%h", i, got, exp); end
    end
    repeat (3) cyc(1'b0);
  endtask
  task automatic test_single;
    cyc(1'b1);
    checks++;
    if ({if1.busy, if0.busy} !== 2'b11) begin errors++; $display("FAIL single_busy got=%b exp=11", {if1.busy, if0.busy}); end
    for (int k = 1; k <= 11; k++) begin
      cyc(k == 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL single_model k=%0d got=%h exp=%h", k, got, exp); end
      if (k == W) begin
        checks++;
        if ({if1.single_evt, if1.mode_chg, if1.double_evt, if1.busy, if1.mode} !== 6'b110001)
          begin errors++; $display("FAIL single_at_win got=%b exp=110001", {if1.single_evt, if1.mode_chg, if1.double_evt, if1.busy, if1.mode}); end
      end
    end
  endtask
  task automatic test_wrap;
    logic [1:0] e1 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] e0 [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    @(negedge clk);
    rst_n = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 20; j++) begin
        cyc(j == 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_model p=%0d j=%0d got=%h exp=%h", p, j, got, exp); end
        if (j == W) begin
          checks++;
          if ({if1.mode, if0.mode, if0.mode_chg} !== {e1[p], e0[p], 1'b1})
            begin errors++; $display("FAIL wrap_seq p=%0d got=%b exp=%b", p, {if1.mode, if0.mode, if0.mode_chg}, {e1[p], e0[p], 1'b1}); end
        end
      end
  endtask
  task automatic test_double;
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 12; j++) begin
        cyc(j == 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL double_pre p=%0d j=%0d got=%h exp=%h", p, j, got, exp); end
      end
    checks++;
    if (if1.mode !== 2'd2) begin errors++; $display("FAIL double_premode got=%0d exp=2", if1.mode); end
    for (int k = 0; k <= 12; k++) begin
      cyc(k == 0 || k == 5);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL double_model k=%0d got=%h exp=%h", k, got, exp); end
      if (k == 5) begin
        checks++;
        if (got !== 12'b00_1010_00_1010) begin errors++; $display("FAIL double_evt got=%b exp=001010001010", got); end
      end
      if (k == W) begin
        checks++;
        if ({if1.single_evt, if0.single_evt} !== 2'b00) begin errors++; $display("FAIL double_nosingle got=%b exp=00", {if1.single_evt, if0.single_evt}); end
      end
    end
  endtask
  task automatic test_boundary;
    for (int k = 0; k <= 12; k++) begin
      cyc(k == 0 || k == W);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bound8_model k=%0d got=%h exp=%h", k, got, exp); end
      if (k == W) begin
        checks++;
        if ({if1.double_evt, if1.single_evt, if1.busy, if1.mode} !== 5'b10000)
          begin errors++; $display("FAIL bound8_double got=%b exp=10000", {if1.double_evt, if1.single_evt, if1.busy, if1.mode}); end
      end
    end
    for (int k = 0; k <= 20; k++) begin
      cyc(k == 0 || k == W + 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bound9_model k=%0d got=%h exp=%h", k, got, exp); end
      if (k == W || k == 2 * W + 1) begin
        checks++;
        if ({if1.single_evt, if1.double_evt} !== 2'b10) begin errors++; $display("FAIL bound9_single k=%0d got=%b exp=10", k, {if1.single_evt, if1.double_evt}); end
      end
      if (k == W + 1) begin
        checks++;
        if (if1.busy !== 1'b1) begin errors++; $display("FAIL bound9_reopen got=%b exp=1", if1.busy); end
      end
    end
  endtask
  task automatic test_reset_mid;
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    @(negedge clk);
    tick = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL midreset_async got=%h exp=000", got); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1);
      checks++;
      if (got !== 12'h000) begin errors++; $display("FAIL midreset_hold i=%0d got=%h exp=000", i, got); end
    end
    cyc(1'b0);
    cyc(1'b1);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL midreset_model k=%0d got=%h exp=%h", k, got, exp); end
      if (k == W) begin
        checks++;
        if ({if1.single_evt, if1.mode, if0.single_evt, if0.mode} !== 6'b101_101)
          begin errors++; $display("FAIL midreset_single got=%b exp=101101", {if1.single_evt, if1.mode, if0.single_evt, if0.mode}); end
      end
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 25);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_double;
    test_boundary;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
